dgs_blink_decoder: RTL and testbench
====================================

# dgs_blink_decoder

Receiving end of the diagnostic-blink link. Samples a serial blink line driven by the diagnostic blink encoder (LED drive looped back, or an optical pickup), recovers frame alignment and reconstructs the per-period status mask. Sits on the test or monitor side of a board-to-board diagnostic path. Emits each decoded mask with a one-cycle valid strobe, and flags framing violations.

## Interface
- FREQ_HZ, 100_000_000, CLK frequency; must equal the encoder's.
- PERIOD_US, 1_000_000, frame period in µs; must equal the encoder's.
- PULSE_US, 100_000, slot width in µs; must equal the encoder's.
- Derived, not overridable:
  - PULSE = (FREQ_HZ/1_000_000)*PULSE_US
  - PERIOD = (FREQ_HZ/1_000_000)*PERIOD_US
  - QUANT_CNT = (PERIOD_US/PULSE_US)/2
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- BLINK_IN  in  1  blink line; asynchronous to CLK.
- MASK_OUT  out  QUANT_CNT  last decoded mask; bit k = even slot 2k. Holds value between frames.
- MASK_VALID  out  1  one-cycle pulse when MASK_OUT updates.
- LOCKED  out  1  level; high while frame-aligned.
- ERR  out  1  one-cycle pulse on a framing violation.

## Operation
- Link convention: transmitter keeps MASK[0]=1 (sync bit) whenever the decoder is in use. Decoded bit 0 is therefore always 1.
- BLINK_IN passes through a 2-FF synchronizer, then a registered rising-edge detector. All decisions use the synchronized signal `s`.
- FSM states:
  - HUNT: `idle_cnt` counts consecutive cycles with `s`=0 and saturates at PERIOD. Any `s`=1 clears it. When it reaches PERIOD → ARMED.
  - ARMED: waits for a rising edge of `s`. On the edge, `cntr`←0 and state → LOCK. A high level without an edge cannot occur here, since `s` is low on entry.
  - LOCK: `cntr` free-runs 0..PERIOD-1 and wraps.
    - Even slot j=2k: sample `s` at `cntr`==j*PULSE+PULSE/2 into `shadow[k]`.
    - Odd slot: sample at the same offset; `s` must be 0.
    - At `cntr`==PERIOD-1: MASK_OUT←shadow, pulse MASK_VALID, clear shadow.
- Framing errors, checked in LOCK only:
  - slot-0 sample = 0 (sync lost), or
  - any odd-slot sample = 1.
  - Response: pulse ERR, go to HUNT, clear `idle_cnt` and shadow, and suppress MASK_VALID for that frame. MASK_OUT keeps its old value.
- No drift tracking. The counter is phased once per lock, at the ARMED→LOCK edge.
- Width rules:
  - `cntr`: $clog2(PERIOD) bits.
  - `idle_cnt`: $clog2(PERIOD+1) bits, saturating.
  - Sample-point constants are computed at elaboration; no runtime multiply.

## Timing
- Reset values: MASK_OUT=0, MASK_VALID=0, LOCKED=0, ERR=0, state=HUNT, all counters 0, synchronizer flops 0.
- RST assertion clears everything immediately (asynchronously), mid-frame included.
- Input-to-edge latency: 3 cycles (2 sync + 1 edge register). This is constant, so sample points need no compensation.
- LOCKED is registered: high the cycle after entering LOCK, low the cycle after leaving it.
- MASK_VALID and ERR are registered and never high together.
- Frame boundaries:
  - First MASK_VALID occurs PERIOD cycles after the locking edge is detected, then every PERIOD cycles.
  - A mask change at an encoder frame boundary appears in the next MASK_VALID.
- Simultaneous events: if an error check fires on the same cycle as `cntr`==PERIOD-1, ERR wins and MASK_VALID is suppressed.

## Structure
- Shared package `dgs_blink_pkg` holds:
  - functions deriving PULSE, PERIOD and QUANT_CNT from FREQ_HZ, PERIOD_US and PULSE_US, so encoder and decoder use the same derivation;
  - the FSM state encoding (HUNT, ARMED, LOCK).
- One sub-module: `bit_sync_2ff` (2-flop synchronizer with async active-high reset), reused elsewhere.
- The rest is a single module: FSM, counters, sample decoder and output registers.

## Test plan
Simulation parameters: FREQ_HZ=10_000_000, PERIOD_US=100, PULSE_US=10, giving PULSE=100, PERIOD=1000, QUANT_CNT=5. The encoder model drives BLINK_IN.

- Line low 1200 cycles, then encoder with MASK=5'b10101 → LOCKED=1 after the first edge; MASK_VALID every 1000 cycles with MASK_OUT=5'b10101; ERR never asserts.
- While locked, switch MASK 5'b10101→5'b00011 at a frame boundary → next MASK_VALID carries 5'b00011; no ERR.
- Force BLINK_IN=1 for cycles 320–380 of a frame (odd slot 3) → one ERR pulse, LOCKED→0, no MASK_VALID for that frame, MASK_OUT unchanged; relock after ≥1000 low cycles plus an edge.
- While locked, encoder MASK=5'b00000 → ERR at the slot-0 sample of that frame, state HUNT; after the line stays low 1000 cycles, MASK=5'b00001 relocks.
- Line toggling every 500 cycles from reset → idle run never reaches 1000, so LOCKED, MASK_VALID and ERR stay 0.
- Assert RST at cycle 450 of a locked frame → all outputs 0 in the same cycle, no MASK_VALID at frame end; after release, normal relock.

Source files
------------

// File: rtl/dgs_blink_pkg.sv
// Shared definitions for the diagnostic-blink link: timing derivation used by
// both encoder and decoder, plus the decoder FSM state encoding.
package dgs_blink_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    LOCK  = 2'd2
  } blink_state_e;

  function automatic int calc_pulse(input int freq_hz, input int pulse_us);
    return (freq_hz / 1_000_000) * pulse_us;
  endfunction

  function automatic int calc_period(input int freq_hz, input int period_us);
    return (freq_hz / 1_000_000) * period_us;
  endfunction

  // Half the slots carry mask bits; the odd ones are guard slots.
  function automatic int calc_quant(input int period_us, input int pulse_us);
    return (period_us / pulse_us) / 2;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, async active-high reset.
module bit_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dgs_blink_decoder.sv
// Blink-line receiver: hunts for an idle gap, phases a frame counter on the
// next rising edge, then samples slot centres to rebuild the status mask.
module dgs_blink_decoder
  import dgs_blink_pkg::*;
#(
  parameter int FREQ_HZ   = 100_000_000,
  parameter int PERIOD_US = 1_000_000,
  parameter int PULSE_US  = 100_000,
  localparam int PULSE     = calc_pulse(FREQ_HZ, PULSE_US),
  localparam int PERIOD    = calc_period(FREQ_HZ, PERIOD_US),
  localparam int QUANT_CNT = calc_quant(PERIOD_US, PULSE_US)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 BLINK_IN,
  output logic [QUANT_CNT-1:0] MASK_OUT,
  output logic                 MASK_VALID,
  output logic                 LOCKED,
  output logic                 ERR
);

  localparam int CW    = $clog2(PERIOD);
  localparam int IW    = $clog2(PERIOD + 1);
  localparam int NSLOT = 2 * QUANT_CNT;
  localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(PERIOD);

  logic s;
  logic s_d1_q, rise_q, rise_d;
  blink_state_e state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [CW-1:0] cntr_q, cntr_d;
  logic [QUANT_CNT-1:0] shadow_q, shadow_d, mask_q, mask_d;
  logic valid_q, valid_d, err_q, err_d, locked_q, locked_d;
  logic frame_err;
  logic [NSLOT-1:0] hit;

  bit_sync_2ff u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (BLINK_IN),
    .q   (s)
  );

  // Slot-centre comparators against elaboration-time constants.
  for (genvar j = 0; j < NSLOT; j++) begin : g_sp
    localparam logic [CW-1:0] SP = CW'(j * PULSE + PULSE / 2);
    assign hit[j] = (cntr_q == SP);
  end

  assign rise_d = s & ~s_d1_q;

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    cntr_d    = cntr_q;
    shadow_d  = shadow_q;
    mask_d    = mask_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      HUNT: begin
        if (s) begin
          idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
          if (idle_d == IDLE_MAX) state_d = ARMED;
        end
      end
      ARMED: begin
        if (rise_q) begin
          cntr_d  = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        cntr_d = (cntr_q == LAST) ? '0 : cntr_q + 1'b1;
        for (int j = 0; j < NSLOT; j++) begin
          if (hit[j]) begin
            if (j % 2 == 0) shadow_d[j/2] = s;
            else if (s)     frame_err = 1'b1;
            if (j == 0 && !s) frame_err = 1'b1;
          end
        end
        // A violation drops the frame entirely, even at the wrap cycle.
        if (frame_err) begin
          err_d    = 1'b1;
          state_d  = HUNT;
          idle_d   = '0;
          shadow_d = '0;
        end else if (cntr_q == LAST) begin
          mask_d   = shadow_d;
          valid_d  = 1'b1;
          shadow_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase
    locked_d = (state_q == LOCK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_d1_q   <= 1'b0;
      rise_q   <= 1'b0;
      state_q  <= HUNT;
      idle_q   <= '0;
      cntr_q   <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      s_d1_q   <= s;
      rise_q   <= rise_d;
      state_q  <= state_d;
      idle_q   <= idle_d;
      cntr_q   <= cntr_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign MASK_OUT   = mask_q;
  assign MASK_VALID = valid_q;
  assign LOCKED     = locked_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_dgs_blink_decoder.sv
// Drives the decoder from a frame-level encoder model and compares the logged
// MASK_VALID/ERR events against the masks of frames expected to decode.
module tb_dgs_blink_decoder;

  localparam int PULSE  = 100;
  localparam int PERIOD = 1000;
  localparam int QC     = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          BLINK_IN;
  logic [QC-1:0] MASK_OUT;
  logic          MASK_VALID, LOCKED, ERR;

  int passed = 0, total = 0;
  int cyc = 0, both_cnt = 0;
  int fstart, run_start, gstart;
  logic [QC-1:0] v_mask[$];
  int            v_cyc[$];
  int            e_cyc[$];
  logic [QC-1:0] exp_q[$];
  logic [QC-1:0] m [7];
  logic [QC-1:0] ra, rb;

  dgs_blink_decoder #(
    .FREQ_HZ   (10_000_000),
    .PERIOD_US (100),
    .PULSE_US  (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BLINK_IN   (BLINK_IN),
    .MASK_OUT   (MASK_OUT),
    .MASK_VALID (MASK_VALID),
    .LOCKED     (LOCKED),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  // Event log, sampled shortly after each active edge.
  always @(posedge CLK) begin
    cyc++;
    #2;
    if (!RST) begin
      if (MASK_VALID) begin
        v_mask.push_back(MASK_OUT);
        v_cyc.push_back(cyc);
      end
      if (ERR) e_cyc.push_back(cyc);
      if (MASK_VALID && ERR) both_cnt++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic idle(input int n, input logic lvl);
    repeat (n) begin
      @(negedge CLK);
      BLINK_IN = lvl;
    end
  endtask

  // One encoder frame: even slot 2k carries mask bit k, odd slots low.
  task automatic frame(input logic [QC-1:0] mk, input int g_lo, input int g_hi,
                       input int rst_at);
    for (int c = 0; c < PERIOD; c++) begin
      @(negedge CLK);
      if (c == 0) fstart = cyc;
      BLINK_IN = (((c / PULSE) % 2 == 0) && mk[c / (2 * PULSE)]) ||
                 (c >= g_lo && c <= g_hi);
      if (c == rst_at) begin
        RST = 1'b1;
        #1;
        chk("rst_async_mask", MASK_OUT, 0);
        chk("rst_async_valid", MASK_VALID, 0);
        chk("rst_async_locked", LOCKED, 0);
        chk("rst_async_err", ERR, 0);
      end
      if (c == rst_at + 3) RST = 1'b0;
    end
  endtask

  task automatic check_run(input string tag);
    int lat;
    chk({tag, "_nvalid"}, v_mask.size(), exp_q.size());
    for (int i = 0; i < v_mask.size() && i < exp_q.size(); i++) begin
      chk({tag, "_mask"}, v_mask[i], exp_q[i]);
      if (i == 0) begin
        lat = v_cyc[0] - run_start;
        chk({tag, "_first_lat_ok"}, (lat >= PERIOD && lat <= PERIOD + 10), 1);
      end else begin
        chk({tag, "_gap"}, v_cyc[i] - v_cyc[i-1], PERIOD);
      end
    end
  endtask

  task automatic clear_logs();
    v_mask.delete();
    v_cyc.delete();
    e_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    BLINK_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    BLINK_IN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_mask", MASK_OUT, 0);
    chk("reset_valid", MASK_VALID, 0);
    chk("reset_locked", LOCKED, 0);
    chk("reset_err", ERR, 0);
    RST = 1'b0;

    // Lock, steady frames, random masks, a boundary mask change, then a glitch.
    m[0] = 5'b10101;
    m[1] = 5'b10101;
    for (int i = 2; i < 5; i++) m[i] = 5'($urandom) | 5'd1;
    m[5] = 5'b00011;
    m[6] = 5'b10101;
    idle(1200, 1'b0);
    chk("hunt_not_locked", LOCKED, 0);
    for (int i = 0; i < 7; i++) begin
      frame(m[i], -1, -2, -1);
      if (i == 0) begin
        run_start = fstart;
        chk("locked_after_edge", LOCKED, 1);
      end
      exp_q.push_back(m[i]);
    end
    frame(5'b10101, 320, 380, -1);
    gstart = fstart;
    check_run("steady");
    chk("glitch_err_count", e_cyc.size(), 1);
    if (e_cyc.size() > 0)
      chk("glitch_err_pos_ok", (e_cyc[0] - gstart >= 350 && e_cyc[0] - gstart <= 360), 1);
    chk("glitch_unlocked", LOCKED, 0);
    chk("glitch_mask_hold", MASK_OUT, m[6]);
    clear_logs();

    // Relock, then lose sync with an all-zero mask.
    ra = 5'($urandom) | 5'd1;
    rb = 5'($urandom) | 5'd1;
    idle(1200, 1'b0);
    frame(ra, -1, -2, -1);
    run_start = fstart;
    frame(rb, -1, -2, -1);
    exp_q.push_back(ra);
    exp_q.push_back(rb);
    frame(5'b00000, -1, -2, -1);
    gstart = fstart;
    check_run("sync");
    chk("sync_err_count", e_cyc.size(), 1);
    if (e_cyc.size() > 0)
      chk("sync_err_pos_ok", (e_cyc[0] - gstart >= 50 && e_cyc[0] - gstart <= 60), 1);
    chk("sync_unlocked", LOCKED, 0);
    chk("sync_mask_hold", MASK_OUT, rb);
    clear_logs();
    idle(1000, 1'b0);
    frame(5'b00001, -1, -2, -1);
    run_start = fstart;
    frame(5'b00001, -1, -2, -1);
    idle(20, 1'b0);
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00001);
    check_run("relock");
    chk("relock_err_count", e_cyc.size(), 0);

    // Toggling line never presents a full idle period.
    do_reset();
    clear_logs();
    for (int i = 0; i < 12; i++) idle(500, (i % 2 == 0));
    chk("toggle_nvalid", v_mask.size(), 0);
    chk("toggle_nerr", e_cyc.size(), 0);
    chk("toggle_locked", LOCKED, 0);

    // Reset in the middle of a locked frame.
    clear_logs();
    idle(1200, 1'b0);
    frame(5'b10101, -1, -2, -1);
    run_start = fstart;
    frame(5'b10101, -1, -2, -1);
    exp_q.push_back(5'b10101);
    exp_q.push_back(5'b10101);
    frame(5'b10101, -1, -2, 450);
    check_run("midrst");
    chk("midrst_nerr", e_cyc.size(), 0);
    chk("midrst_mask_cleared", MASK_OUT, 0);
    clear_logs();
    ra = 5'($urandom) | 5'd1;
    rb = 5'($urandom) | 5'd1;
    idle(1200, 1'b0);
    frame(ra, -1, -2, -1);
    run_start = fstart;
    frame(rb, -1, -2, -1);
    idle(20, 1'b0);
    exp_q.push_back(ra);
    exp_q.push_back(rb);
    check_run("postrst");
    chk("postrst_nerr", e_cyc.size(), 0);
    chk("valid_err_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
